pic24_rst_ctrl: RTL
===================

# pic24_rst_ctrl

Reset and instruction-clock sequencer inside `pic24_top`. It receives the board clock and external reset that the top-level testbench drives, and it stretches and orders the reset release: peripherals first, CPU core second. In RUN it generates the Fcy instruction-cycle enable. It also takes internal reset requests (software RESET instruction, watchdog timeout, trap conflict) and records every reset cause in a sticky RCON-style register.

## Interface
- `RST_HOLD_CYCLES`, default 8: cycles both resets stay asserted after any reset source is removed or fires; must be ≥1.
- `STARTUP_CYCLES`, default 64: cycles between peripheral release and CPU release; must be ≥1.
- `CLK_DIV`, default 2: clk50M_i cycles per instruction cycle; must be ≥1.
- `clk50M_i  in  1  single system clock; all logic on rising edge.`
- `rst_ni  in  1  external reset; synchronous, active-low.`
- `swrst_i  in  1  software RESET instruction, one-cycle pulse from core.`
- `wdt_to_i  in  1  watchdog timeout pulse.`
- `trap_i  in  1  trap-conflict reset request pulse.`
- `rcon_clr_i  in  4  per-bit clear strobe for rcon_o, same bit order.`
- `periph_rst_no  out  1  peripheral reset, active-low, registered.`
- `cpu_rst_no  out  1  CPU core reset, active-low, registered.`
- `fcy_en_o  out  1  instruction-cycle clock enable, one cycle wide.`
- `rcon_o  out  4  sticky reset causes {TRAPR, SWR, WDTO, POR}.`

## Operation
- States: POR, HOLD, STARTUP, RUN. One hold/startup counter, sized for max(RST_HOLD_CYCLES, STARTUP_CYCLES). One divider counter, range 0..CLK_DIV-1.
- rst_ni=0 at an edge overrides everything in any state, mid-sequence included:
  - state goes to POR; both counters go to 0.
  - periph_rst_no=0, cpu_rst_no=0, fcy_en_o=0, rcon_o=4'b0001.
  - Internal requests and rcon_clr_i are ignored in that cycle.
- POR → HOLD on the first edge with rst_ni=1. Counter loads 0.
- HOLD: counter increments each edge. When counter == RST_HOLD_CYCLES-1, go to STARTUP, load counter 0, set periph_rst_no=1.
- STARTUP: counter increments each edge. When counter == STARTUP_CYCLES-1, go to RUN, set cpu_rst_no=1, load divider 0.
- RUN: divider increments and wraps at CLK_DIV-1. fcy_en_o = (state==RUN) && (divider==CLK_DIV-1), decoded from registers. With CLK_DIV=1, fcy_en_o stays high throughout RUN.
- Internal request (any of swrst_i, wdt_to_i, trap_i high at an edge while rst_ni=1):
  - In HOLD, STARTUP or RUN: go to HOLD, counter 0, periph_rst_no=0, cpu_rst_no=0, divider 0.
  - A request during HOLD restarts the hold count.
  - Set the matching rcon bit(s). Simultaneous requests set all matching bits.
- rcon_o: each bit is sticky until software clears it with rcon_clr_i[n]. If set and clear hit the same bit in the same cycle, set wins. The POR bit is set only by rst_ni=0.
- Not outputs: state and counters are internal.

## Timing
- Edge 0 = first rising edge sampling rst_ni=1 after reset. H = RST_HOLD_CYCLES, S = STARTUP_CYCLES.
- periph_rst_no rises after edge H.
- cpu_rst_no rises after edge H+S.
- First fcy_en_o pulse is in the cycle after edge H+S+CLK_DIV-1. Later pulses follow every CLK_DIV cycles.
- Internal request sampled at edge E: both resets low after E. periph_rst_no high again after E+H. cpu_rst_no high after E+H+S.
- fcy_en_o drops in the cycle after E.
- rcon_o updates after the sampling edge: one cycle latency for both set and clear.
- No combinational path from any input to any output.

## Test plan
- Defaults (H=8, S=64, DIV=2); rst_ni low 3 cycles, then high:
  - periph_rst_no rises after edge 8; cpu_rst_no rises after edge 72.
  - fcy_en_o pulses in the cycles after edges 73, 75, 77, …
  - rcon_o=4'b0001.
- In RUN, rcon_clr_i=4'b0001 for one cycle → rcon_o=0. Then one-cycle swrst_i at edge E:
  - both resets low after E; fcy_en_o=0.
  - rcon_o=4'b0100; periph high after E+8; cpu high after E+72.
- wdt_to_i and trap_i pulsed in the same cycle in RUN → rcon_o=4'b1010, single 8+64 sequence.
- swrst_i pulsed 5 cycles into HOLD → hold count restarts; periph_rst_no rises 8 edges after the pulse edge.
- In RUN with rcon_o=4'b0100, drive rcon_clr_i=4'b0100 and swrst_i at the same edge → SWR stays 1.
- rst_ni pulled low for one edge in mid-STARTUP:
  - both resets low; rcon_o=4'b0001, previous causes cleared.
  - full sequence from edge 0 again.
- CLK_DIV=1: fcy_en_o is high continuously from the cycle after edge H+S onward.

Source files
------------

// File: rtl/pic24_rst_ctrl.sv
// rtl/pic24_rst_ctrl.sv - reset release sequencer, instruction-cycle enable and sticky reset-cause register
module pic24_rst_ctrl #(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int STARTUP_CYCLES  = 64,
    parameter int CLK_DIV         = 2
) (
    input  logic       clk50M_i,
    input  logic       rst_ni,
    input  logic       swrst_i,
    input  logic       wdt_to_i,
    input  logic       trap_i,
    input  logic [3:0] rcon_clr_i,
    output logic       periph_rst_no,
    output logic       cpu_rst_no,
    output logic       fcy_en_o,
    output logic [3:0] rcon_o
);

    // One counter serves both the hold and the startup phase, so size it for the longer one.
    localparam int CNT_MAX = (RST_HOLD_CYCLES > STARTUP_CYCLES) ? RST_HOLD_CYCLES : STARTUP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STARTUP = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             periph_d;
    logic             cpu_d;
    logic [3:0]       rcon_d;
    logic             req;
    logic [3:0]       rcon_set;

    // Any internal source restarts the sequence; the POR cause bit is never set from here.
    assign req      = swrst_i | wdt_to_i | trap_i;
    assign rcon_set = {trap_i, swrst_i, wdt_to_i, 1'b0};

    // State register: external reset wins over every other input, including the clear strobes.
    always_ff @(posedge clk50M_i) begin
        if (!rst_ni) begin
            state_q       <= ST_POR;
            cnt_q         <= '0;
            div_q         <= '0;
            periph_rst_no <= 1'b0;
            cpu_rst_no    <= 1'b0;
            rcon_o        <= 4'b0001;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            periph_rst_no <= periph_d;
            cpu_rst_no    <= cpu_d;
            rcon_o        <= rcon_d;
        end
    end

    // Next-state logic: phase counting, divider wrap, and restart on an internal request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            ST_POR: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_STARTUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STARTUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    div_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
                div_d   = '0;
            end
        endcase
        if (req && (state_q != ST_POR)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            div_d   = '0;
        end
    end

    // Output decode: reset levels follow the next state so they register together with it.
    always_comb begin
        periph_d = (state_d == ST_STARTUP) || (state_d == ST_RUN);
        cpu_d    = (state_d == ST_RUN);
        // Set beats clear on the same bit in the same cycle.
        rcon_d   = (rcon_o & ~rcon_clr_i) | rcon_set;
    end

    // Instruction-cycle enable decoded from registered state only, so no input reaches it directly.
    assign fcy_en_o = (state_q == ST_RUN) && (div_q == DIV_LAST);

endmodule
